// File: rtl/uart_pkg.sv
// Shared UART definitions: bit timing helpers, TX FSM encoding and frame length.
// The UART receiver uses these too.
package uart_pkg;

    // Start bit + 8 data bits + stop bit.
    localparam int unsigned FRAME_BITS = 10;

    typedef enum logic {
        StIdle,
        StFrame
    } tx_state_e;

    // Bit period in core clock cycles. The division truncates.
    function automatic int unsigned symbol_edge_time(input int unsigned clock_freq,
                                                     input int unsigned baud_rate);
        return clock_freq / baud_rate;
    endfunction

    // Baud counter width. A one-cycle bit period still needs one counter bit.
    function automatic int unsigned baud_cnt_width(input int unsigned clock_freq,
                                                   input int unsigned baud_rate);
        int unsigned set;
        set = clock_freq / baud_rate;
        return (set > 1) ? $clog2(set) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO. Its occupancy count is registered.
// A push while full or a pop while empty is ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter. Bytes arrive over ready/valid and wait in a FIFO.
// Frames go out back-to-back while the FIFO holds data.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 125_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 data_in,
    input  logic                       data_in_valid,
    output logic                       data_in_ready,
    output logic                       serial_out,
    output logic                       tx_busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int unsigned SymbolEdgeTime = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned BaudW          = baud_cnt_width(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned BitIdxW        = $clog2(FRAME_BITS);
    localparam int unsigned FifoCntW       = $clog2(DEPTH + 1);

    localparam logic [BaudW-1:0]   BaudMax = BaudW'(SymbolEdgeTime - 1);
    localparam logic [BitIdxW-1:0] LastBit = BitIdxW'(FRAME_BITS - 1);

    tx_state_e                 state_q, state_d;
    logic [FRAME_BITS-1:0]     shift_q, shift_d;
    logic [BitIdxW-1:0]        bit_idx_q, bit_idx_d;
    logic [BaudW-1:0]          baud_q, baud_d;

    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [7:0]                fifo_rdata;
    logic [FifoCntW-1:0]       fifo_cnt;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (data_in_valid && data_in_ready),
        .wdata_i (data_in),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign data_in_ready = !fifo_full;
    assign fifo_count    = fifo_cnt;
    assign tx_busy       = (state_q == StFrame) || (fifo_cnt != '0);

    // The shift register idles at all ones, so the line is driven straight from a flop.
    assign serial_out = shift_q[0];

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        baud_d    = baud_q;
        fifo_pop  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_d   = {1'b1, fifo_rdata, 1'b0};
                    bit_idx_d = '0;
                    baud_d    = '0;
                    state_d   = StFrame;
                end
            end
            StFrame: begin
                if (baud_q == BaudMax) begin
                    baud_d = '0;
                    if (bit_idx_q == LastBit) begin
                        // End of the stop bit. Chain straight into the next queued byte, if there is one.
                        bit_idx_d = '0;
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            shift_d  = {1'b1, fifo_rdata, 1'b0};
                        end else begin
                            shift_d = '1;
                            state_d = StIdle;
                        end
                    end else begin
                        shift_d   = {1'b1, shift_q[FRAME_BITS-1:1]};
                        bit_idx_d = bit_idx_q + BitIdxW'(1);
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                shift_d = '1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            shift_q   <= '1;
            bit_idx_q <= '0;
            baud_q    <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            baud_q    <= baud_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered. Each cycle the DUT is checked against a model built on a queue and an elapsed-frame-time count.
// Directed scenarios come first, then a randomized traffic phase.
module tb_uart_tx_buffered;

    localparam int unsigned ClkFreq     = 1000;
    localparam int unsigned BaudRate    = 100;
    localparam int unsigned Depth       = 4;
    localparam int          BitCycles   = 10;
    localparam int          FrameCycles = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_in_valid = 1'b0;
    logic       data_in_ready;
    logic       serial_out;
    logic       tx_busy;
    logic [2:0] fifo_count;

    int tests = 0;
    int fails = 0;

    // Reference model: the pending bytes, plus the byte on the line and the cycles elapsed in its frame.
    logic [7:0] mq[$];
    bit         m_active = 1'b0;
    logic [7:0] m_cur = 8'h00;
    int         m_t = 0;

    always #5 clk = ~clk;

    uart_tx_buffered #(
        .CLOCK_FREQ (ClkFreq),
        .BAUD_RATE  (BaudRate),
        .DEPTH      (Depth)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .serial_out    (serial_out),
        .tx_busy       (tx_busy),
        .fifo_count    (fifo_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic line_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return b[idx-1];
    endfunction

    task automatic model_reset();
        mq.delete();
        m_active = 1'b0;
        m_t = 0;
    endtask

    // Advance the model by one rising edge, using the inputs as they were before the edge.
    task automatic model_edge();
        bit push;
        int sz;
        if (!rst_n) begin
            model_reset();
            return;
        end
        sz = mq.size();
        push = data_in_valid && (sz != Depth);
        if (m_active) begin
            m_t++;
            if (m_t == FrameCycles) begin
                if (sz > 0) begin
                    m_cur = mq.pop_front();
                    m_t = 0;
                end else begin
                    m_active = 1'b0;
                end
            end
        end else if (sz > 0) begin
            m_cur = mq.pop_front();
            m_active = 1'b1;
            m_t = 0;
        end
        if (push) mq.push_back(data_in);
    endtask

    task automatic model_check();
        chk("serial_out", 32'(serial_out), m_active ? 32'(line_bit(m_cur, m_t / BitCycles)) : 32'd1);
        chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
        chk("data_in_ready", 32'(data_in_ready), 32'(mq.size() != Depth));
        chk("tx_busy", 32'(tx_busy), 32'(m_active || (mq.size() != 0)));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        model_check();
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (tx_busy && n < limit) begin
            step();
            n++;
        end
        chk("drain_idle", 32'(tx_busy), 32'd0);
    endtask

    initial begin
        logic [7:0] burst [5];
        int busy_cycles;
        int idx;
        int guard;
        int low_cnt;
        logic rdy;

        // Reset state.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_serial_out", 32'(serial_out), 32'd1);
        chk("rst_ready", 32'(data_in_ready), 32'd1);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        rst_n = 1'b1;
        step();

        // A single byte 0x55 gives one 100-cycle frame, and tx_busy covers accept through the stop bit.
        data_in = 8'h55;
        data_in_valid = 1'b1;
        step();
        data_in_valid = 1'b0;
        chk("single_count_after_accept", 32'(fifo_count), 32'd1);
        busy_cycles = tx_busy ? 1 : 0;
        step();
        chk("single_start_bit", 32'(serial_out), 32'd0);
        chk("single_count_after_pop", 32'(fifo_count), 32'd0);
        if (tx_busy) busy_cycles++;
        for (int i = 0; i < 300 && tx_busy; i++) begin
            step();
            if (tx_busy) busy_cycles++;
        end
        chk("single_busy_cycles", 32'(busy_cycles), 32'(FrameCycles + 1));

        // A five-byte burst goes out as five back-to-back frames.
        burst[0] = 8'hA5; burst[1] = 8'h3C; burst[2] = 8'hFF; burst[3] = 8'h00; burst[4] = 8'h81;
        idx = 0;
        guard = 0;
        busy_cycles = 0;
        while (idx < 5 && guard < 50) begin
            data_in = burst[idx];
            data_in_valid = 1'b1;
            rdy = data_in_ready;
            step();
            if (rdy) idx++;
            if (tx_busy) busy_cycles++;
            guard++;
        end
        data_in_valid = 1'b0;
        chk("burst_all_accepted", 32'(idx), 32'd5);
        chk("burst_count_peak", 32'(fifo_count), 32'd4);
        for (int i = 0; i < 800 && tx_busy; i++) begin
            step();
            if (tx_busy) busy_cycles++;
        end
        chk("burst_busy_cycles", 32'(busy_cycles), 32'(5 * FrameCycles + 1));

        // Valid stays high while the FIFO is full. The extra bytes must be dropped.
        for (int i = 0; i < 8; i++) begin
            data_in = 8'(8'h40 + i);
            data_in_valid = 1'b1;
            step();
        end
        chk("full_count_held", 32'(fifo_count), 32'd4);
        chk("full_ready_low", 32'(data_in_ready), 32'd0);
        data_in = 8'hEE;
        step();
        chk("full_count_still", 32'(fifo_count), 32'd4);
        data_in_valid = 1'b0;
        drain(1000);

        // Reset in the middle of bit 4 of 0xF0, with two bytes queued.
        data_in = 8'hF0;
        data_in_valid = 1'b1;
        step();
        data_in = 8'h11;
        step();
        data_in = 8'h22;
        step();
        data_in_valid = 1'b0;
        guard = 0;
        while (!(m_active && m_t == 45) && guard < 200) begin
            step();
            guard++;
        end
        chk("midrst_reached_bit4", 32'(m_t / BitCycles), 32'd4);
        chk("midrst_queued", 32'(fifo_count), 32'd2);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_serial_high", 32'(serial_out), 32'd1);
        chk("midrst_count_zero", 32'(fifo_count), 32'd0);
        chk("midrst_busy_low", 32'(tx_busy), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        low_cnt = 0;
        for (int i = 0; i < 150; i++) begin
            step();
            if (serial_out !== 1'b1) low_cnt++;
        end
        chk("midrst_no_frames", 32'(low_cnt), 32'd0);

        // A push lands on the same edge as the end-of-stop pop, with two bytes queued.
        data_in = 8'hC3;
        data_in_valid = 1'b1;
        step();
        data_in = 8'h96;
        step();
        data_in = 8'h0F;
        step();
        data_in_valid = 1'b0;
        guard = 0;
        while (!(m_active && m_t == FrameCycles - 1 && mq.size() == 2) && guard < 200) begin
            step();
            guard++;
        end
        chk("simul_count_before", 32'(fifo_count), 32'd2);
        data_in = 8'h5A;
        data_in_valid = 1'b1;
        step();
        data_in_valid = 1'b0;
        chk("simul_count_kept", 32'(fifo_count), 32'd2);
        chk("simul_next_start", 32'(serial_out), 32'd0);
        chk("simul_busy", 32'(tx_busy), 32'd1);
        drain(1000);

        // Randomized traffic: a heavy phase that keeps the FIFO full, then a sparse phase.
        for (int i = 0; i < 3000; i++) begin
            data_in = 8'($urandom);
            if (i < 1500) data_in_valid = ($urandom_range(0, 3) == 0);
            else data_in_valid = ($urandom_range(0, 149) == 0);
            step();
        end
        data_in_valid = 1'b0;
        drain(1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
